// File: rtl/multi_source_bit_packer.sv
// Arbitrated multi-source MSB-first bit packer with byte-aligned flush and show-ahead output word FIFO.
// Source 0 has highest priority; the accumulator keeps bits MSB-aligned with zeros below the fill point.
module multi_source_bit_packer #(
  parameter int NUM_SRC    = 3,
  parameter int VAL_W      = 64,
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32,
  localparam int SZ_W      = $clog2(VAL_W + 1),
  localparam int NB        = OUT_W / 8,
  localparam int ACC_W     = VAL_W + OUT_W,
  localparam int FILL_W    = $clog2(ACC_W + 1)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     slice_start,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*VAL_W-1:0] src_val,
  input  logic [NUM_SRC*SZ_W-1:0]  src_size,
  input  logic [NUM_SRC-1:0]       src_flush,
  output logic [NUM_SRC-1:0]       src_ready,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         out_data,
  output logic [NB-1:0]            out_byte_en,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         total_byte_size,
  output logic [FILL_W-1:0]        bit_fill,
  output logic                     err_size,
  output logic                     err_discard
);

  localparam int GW    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = PTR_W + 1;
  localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);
  localparam logic [FILL_W-1:0] ACC_W_F = FILL_W'(ACC_W);
  localparam logic [CW-1:0]     DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [VAL_W:0]    ONE_EXT = {{VAL_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, PAD = 2'd2, TAIL = 2'd3} state_t;

  state_t              state_q;
  logic [ACC_W-1:0]    acc_q;
  logic [FILL_W-1:0]   fill_q;
  logic                flush_pend_q;
  logic [CNT_W-1:0]    total_q;
  logic                err_size_q;
  logic                err_discard_q;
  logic [OUT_W-1:0]    data_q [FIFO_DEPTH];
  logic [NB-1:0]       be_q   [FIFO_DEPTH];
  logic                last_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [CW-1:0]       cnt_q;

  logic [GW-1:0]       grant_s;
  logic                any_valid_s;
  logic                accept_ok_s;
  logic                accept_s;
  logic [SZ_W-1:0]     req_size_s;
  logic                size_err_s;
  logic [SZ_W-1:0]     eff_size_s;
  logic [VAL_W:0]      mask_ext_s;
  logic [VAL_W-1:0]    masked_s;
  logic                req_flush_s;
  logic [FILL_W-1:0]   fill_app_d;
  logic [FILL_W-1:0]   shift_s;
  logic [ACC_W-1:0]    acc_app_d;
  logic [NB-1:0]       tail_be_s;
  logic                pop_s;
  logic                can_push_s;
  logic                discard_s;
  logic                mark_ok_s;
  logic                push_s;
  logic [NB-1:0]       push_be_s;

  // Arbitration, request masking and append alignment for the granted source.
  always_comb begin
    grant_s     = '0;
    any_valid_s = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      grant_s     = src_valid[i] ? GW'(i) : grant_s;
      any_valid_s = any_valid_s | src_valid[i];
    end
    accept_ok_s = (state_q == RUN) && (fill_q < OUT_W_F) && !slice_start;
    accept_s    = accept_ok_s && any_valid_s;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = accept_s && (grant_s == GW'(i));
    end
    req_size_s  = src_size[grant_s*SZ_W +: SZ_W];
    req_flush_s = src_flush[grant_s];
    size_err_s  = req_size_s > SZ_W'(VAL_W);
    eff_size_s  = size_err_s ? SZ_W'(VAL_W) : req_size_s;
    mask_ext_s  = (ONE_EXT << eff_size_s) - ONE_EXT;
    masked_s    = src_val[grant_s*VAL_W +: VAL_W] & mask_ext_s[VAL_W-1:0];
    fill_app_d  = fill_q + FILL_W'(eff_size_s);
    shift_s     = ACC_W_F - fill_app_d;
    acc_app_d   = acc_q | ({{OUT_W{1'b0}}, masked_s} << shift_s);
  end

  // FIFO push/pop decisions and tail byte mask.
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      tail_be_s[NB-1-b] = FILL_W'(b) < (fill_q >> 3);
    end
    pop_s      = (cnt_q != '0) && out_ready;
    can_push_s = (cnt_q != DEPTH_C) || out_ready;
    discard_s  = slice_start && (fill_q != '0);
    // A zero-length tail just tags the newest queued word, provided it is not leaving now.
    mark_ok_s  = (cnt_q > CW'(1)) || ((cnt_q == CW'(1)) && !pop_s);
    if (discard_s) begin
      push_s = 1'b0;
    end else if (state_q == DRAIN) begin
      push_s = can_push_s;
    end else if (state_q == TAIL) begin
      push_s = can_push_s && !((fill_q == '0) && mark_ok_s);
    end else begin
      push_s = 1'b0;
    end
    push_be_s = (state_q == DRAIN) ? {NB{1'b1}} : tail_be_s;
  end

  // Packer FSM, accumulator, counters, error flags and output FIFO.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      acc_q         <= '0;
      fill_q        <= '0;
      flush_pend_q  <= 1'b0;
      total_q       <= '0;
      err_size_q    <= 1'b0;
      err_discard_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        be_q[i]   <= '0;
        last_q[i] <= 1'b0;
      end
    end else begin
      if (discard_s) begin
        acc_q        <= '0;
        fill_q       <= '0;
        flush_pend_q <= 1'b0;
        state_q      <= RUN;
      end else begin
        case (state_q)
          RUN: begin
            if (accept_s) begin
              acc_q        <= acc_app_d;
              fill_q       <= fill_app_d;
              flush_pend_q <= req_flush_s;
              err_size_q   <= err_size_q | size_err_s;
              if (fill_app_d >= OUT_W_F) begin
                state_q <= DRAIN;
              end else if (req_flush_s) begin
                state_q <= PAD;
              end else begin
                state_q <= RUN;
              end
            end
          end
          DRAIN: begin
            if (push_s) begin
              acc_q   <= acc_q << OUT_W;
              fill_q  <= fill_q - OUT_W_F;
              total_q <= total_q + CNT_W'(NB);
              if ((fill_q - OUT_W_F) < OUT_W_F) begin
                state_q <= flush_pend_q ? PAD : RUN;
              end
            end
          end
          PAD: begin
            fill_q  <= (fill_q + FILL_W'(7)) & {{(FILL_W-3){1'b1}}, 3'b000};
            state_q <= TAIL;
          end
          TAIL: begin
            if ((fill_q == '0) && mark_ok_s) begin
              last_q[wr_ptr_q - PTR_W'(1)] <= 1'b1;
              flush_pend_q <= 1'b0;
              state_q      <= RUN;
            end else if (push_s) begin
              acc_q        <= '0;
              fill_q       <= '0;
              total_q      <= total_q + CNT_W'(fill_q >> 3);
              flush_pend_q <= 1'b0;
              state_q      <= RUN;
            end
          end
          default: state_q <= RUN;
        endcase
      end
      if (slice_start) begin
        total_q       <= '0;
        err_size_q    <= 1'b0;
        err_discard_q <= discard_s;
      end
      if (push_s) begin
        data_q[wr_ptr_q] <= acc_q[ACC_W-1 -: OUT_W];
        be_q[wr_ptr_q]   <= push_be_s;
        last_q[wr_ptr_q] <= (state_q == TAIL);
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push_s && !pop_s) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (pop_s && !push_s) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign out_valid       = (cnt_q != '0);
  assign out_data        = data_q[rd_ptr_q];
  assign out_byte_en     = be_q[rd_ptr_q];
  assign out_last        = last_q[rd_ptr_q];
  assign total_byte_size = total_q;
  assign bit_fill        = fill_q;
  assign err_size        = err_size_q;
  assign err_discard     = err_discard_q;

endmodule

// File: tb/tb_multi_source_bit_packer.sv
// Scoreboard bench for multi_source_bit_packer: stimulus pushes expected words, a monitor pops and compares.
module tb_multi_source_bit_packer;

  localparam int NUM_SRC = 3;
  localparam int VAL_W   = 64;
  localparam int OUT_W   = 32;
  localparam int SZ_W    = 7;
  localparam int NB      = 4;
  localparam int FILL_W  = 7;

  logic                     clock = 1'b0;
  logic                     reset_n = 1'b0;
  logic                     slice_start = 1'b0;
  logic [NUM_SRC-1:0]       src_valid = '0;
  logic [NUM_SRC*VAL_W-1:0] src_val = '0;
  logic [NUM_SRC*SZ_W-1:0]  src_size = '0;
  logic [NUM_SRC-1:0]       src_flush = '0;
  logic [NUM_SRC-1:0]       src_ready;
  logic                     out_valid;
  logic [OUT_W-1:0]         out_data;
  logic [NB-1:0]            out_byte_en;
  logic                     out_last;
  logic                     out_ready = 1'b1;
  logic [31:0]              total_byte_size;
  logic [FILL_W-1:0]        bit_fill;
  logic                     err_size;
  logic                     err_discard;

  multi_source_bit_packer dut (
    .clock(clock), .reset_n(reset_n), .slice_start(slice_start),
    .src_valid(src_valid), .src_val(src_val), .src_size(src_size), .src_flush(src_flush),
    .src_ready(src_ready), .out_valid(out_valid), .out_data(out_data),
    .out_byte_en(out_byte_en), .out_last(out_last), .out_ready(out_ready),
    .total_byte_size(total_byte_size), .bit_fill(bit_fill),
    .err_size(err_size), .err_discard(err_discard)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  be;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_word(input logic [31:0] d, input logic [3:0] be, input logic last);
    exp_t e;
    e.d = d; e.be = be; e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every word handed to the consumer is compared against the scoreboard head.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got %h/%b/%b expected none", out_data, out_byte_en, out_last);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_data !== e.d || out_byte_en !== e.be || out_last !== e.last) begin
          errors++;
          $display("FAIL word: got %h/%b/%b expected %h/%b/%b",
                   out_data, out_byte_en, out_last, e.d, e.be, e.last);
        end
      end
    end
  end

  task automatic send(input int s, input logic [63:0] v, input logic [6:0] sz, input logic fl);
    bit done;
    done = 1'b0;
    src_valid[s] = 1'b1;
    src_val[s*VAL_W +: VAL_W] = v;
    src_size[s*SZ_W +: SZ_W] = sz;
    src_flush[s] = fl;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clock);
      if (src_ready[s]) done = 1'b1;
      @(posedge clock); #1;
    end
    src_valid[s] = 1'b0;
    src_flush[s] = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no ready expected ready on src %0d", s);
    end
  endtask

  task automatic wait_empty();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clock);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic pulse_slice();
    slice_start = 1'b1;
    @(posedge clock); #1;
    slice_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    idle(2);
    reset_n = 1'b1;
    idle(1);
    @(negedge clock);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_bit_fill", 64'(bit_fill), 64'd0);
    check("rst_total", 64'(total_byte_size), 64'd0);
    check("rst_errs", 64'({err_size, err_discard}), 64'd0);
    check("rst_ready", 64'(src_ready), 64'd0);
    @(posedge clock); #1;

    // Eight nibbles 1..8 form one full word.
    expect_word(32'h12345678, 4'hF, 1'b0);
    for (int k = 1; k <= 8; k++) send(0, 64'(k), 7'd4, 1'b0);
    wait_empty();
    @(negedge clock);
    check("total_after_nibbles", 64'(total_byte_size), 64'd4);
    check("fill_after_nibbles", 64'(bit_fill), 64'd0);
    @(posedge clock); #1;
    pulse_slice();
    @(negedge clock);
    check("total_after_slice", 64'(total_byte_size), 64'd0);
    @(posedge clock); #1;

    // 12-bit flush pads to two bytes.
    expect_word(32'hABC00000, 4'b1100, 1'b1);
    send(1, 64'hABC, 7'd12, 1'b1);
    wait_empty();
    @(negedge clock);
    check("total_after_flush12", 64'(total_byte_size), 64'd2);

    // Priority: src0 beats src2 while both valid.
    expect_word(32'hA5A5A53C, 4'hF, 1'b0);
    @(posedge clock); #1;
    src_val[0 +: VAL_W] = 64'hA5;          src_size[0 +: SZ_W] = 7'd8;
    src_val[2*VAL_W +: VAL_W] = 64'h3C;    src_size[2*SZ_W +: SZ_W] = 7'd8;
    src_valid = 3'b101;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("prio_src0", 64'(src_ready), 64'd1);
      @(posedge clock); #1;
    end
    src_valid = 3'b100;
    @(negedge clock);
    check("prio_src2", 64'(src_ready), 64'd4);
    @(posedge clock); #1;
    src_valid = 3'b000;
    wait_empty();
    @(negedge clock);
    check("total_after_prio", 64'(total_byte_size), 64'd6);
    @(posedge clock); #1;
    pulse_slice();

    // Backpressure: 4 words fill the FIFO, a fifth stalls in the accumulator.
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) expect_word(32'h11110000 + 32'(k), 4'hF, 1'b0);
    for (int k = 0; k < 5; k++) send(0, 64'(32'h11110000 + 32'(k)), 7'd32, 1'b0);
    src_valid[0] = 1'b1;
    src_val[0 +: VAL_W] = 64'h11110005;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("bp_ready_low", 64'(src_ready), 64'd0);
      check("bp_fill32", 64'(bit_fill), 64'd32);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    send(0, 64'h11110005, 7'd32, 1'b0);
    wait_empty();
    @(negedge clock);
    check("total_after_bp", 64'(total_byte_size), 64'd24);
    @(posedge clock); #1;

    // Oversize request is clipped to 64 bits and flagged.
    pulse_slice();
    expect_word(32'hFFFFFFFF, 4'hF, 1'b0);
    expect_word(32'hFFFFFFFF, 4'hF, 1'b0);
    send(2, 64'hFFFFFFFFFFFFFFFF, 7'd70, 1'b0);
    wait_empty();
    @(negedge clock);
    check("err_size_set", 64'(err_size), 64'd1);
    check("total_after_oversize", 64'(total_byte_size), 64'd8);
    check("fill_after_oversize", 64'(bit_fill), 64'd0);
    @(posedge clock); #1;
    pulse_slice();
    @(negedge clock);
    check("err_size_cleared", 64'(err_size), 64'd0);
    check("total_cleared", 64'(total_byte_size), 64'd0);
    check("err_discard_clean", 64'(err_discard), 64'd0);
    @(posedge clock); #1;

    // slice_start with bits pending discards them.
    send(0, 64'hF, 7'd4, 1'b0);
    pulse_slice();
    @(negedge clock);
    check("err_discard_set", 64'(err_discard), 64'd1);
    check("fill_discarded", 64'(bit_fill), 64'd0);
    @(posedge clock); #1;

    // Empty flush with empty FIFO emits a zero marker word.
    expect_word(32'h0, 4'b0000, 1'b1);
    send(1, 64'h0, 7'd0, 1'b1);
    wait_empty();
    @(negedge clock);
    check("err_discard_sticky", 64'(err_discard), 64'd1);
    @(posedge clock); #1;
    pulse_slice();

    // Word-aligned flush tags the queued word as last.
    out_ready = 1'b0;
    expect_word(32'hCAFEBABE, 4'hF, 1'b1);
    send(0, 64'hCAFEBABE, 7'd32, 1'b1);
    idle(6);
    out_ready = 1'b1;
    wait_empty();
    @(negedge clock);
    check("total_after_aligned_flush", 64'(total_byte_size), 64'd4);
    @(posedge clock); #1;

    // Async reset with 20 bits queued.
    send(0, 64'h12345, 7'd20, 1'b0);
    @(negedge clock);
    check("fill_before_reset", 64'(bit_fill), 64'd20);
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(negedge clock);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_fill", 64'(bit_fill), 64'd0);
    check("reset_ready", 64'(src_ready), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle(4);
    check("no_leftover_expect", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
